// File: rtl/io_pins_sequencer.sv
// Shares one bidirectional pin bank between NREQ requesters: round-robin
// arbitration, one single-pin read or write in flight, drive-hold and turnaround timing.
module io_pins_sequencer #(
    parameter int unsigned PINS_COUNT    = 17,
    parameter int unsigned NREQ          = 2,
    parameter int unsigned IDXW          = 5,
    parameter int unsigned HOLD_CYCLES   = 4,
    parameter int unsigned SETTLE_CYCLES = 3
) (
    input  logic                   CLK50,
    input  logic                   RST,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_write,
    input  logic [NREQ*IDXW-1:0]   req_pin,
    input  logic [NREQ-1:0]        req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        rsp_valid,
    output logic                   rsp_data,
    output logic                   rsp_err,
    output logic                   bank_we,
    output logic [PINS_COUNT-1:0]  bank_out,
    input  logic [PINS_COUNT-1:0]  bank_in,
    output logic                   busy
);

    localparam int unsigned PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned HCW  = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned SCW  = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_RESP} state_t;

    state_t                 state, state_nxt;
    logic [PTRW-1:0]        ptr, grant_idx, cand, owner;
    logic                   grant_any, accept;
    logic [IDXW-1:0]        cmd_pin, new_pin;
    logic                   cmd_data, new_write, new_data;
    logic                   pin_ok, new_pin_ok;
    logic [HCW-1:0]         hold_cnt, hold_nxt;
    logic [SCW-1:0]         settle_cnt;
    logic [PINS_COUNT-1:0]  shadow, shadow_nxt;
    logic                   bank_we_nxt, rsp_data_nxt, rsp_err_nxt;
    logic [NREQ-1:0]        rsp_valid_nxt;

    // Round-robin search starting at the pointer
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = PTRW'((32'(ptr) + i) % NREQ);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign accept     = (state == S_IDLE) && grant_any;
    assign new_pin    = req_pin[32'(grant_idx) * IDXW +: IDXW];
    assign new_write  = req_write[grant_idx];
    assign new_data   = req_data[grant_idx];
    assign new_pin_ok = 32'(new_pin) < PINS_COUNT;
    assign pin_ok     = 32'(cmd_pin) < PINS_COUNT;
    assign bank_out   = shadow;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[grant_idx] = 1'b1;
    end

    // State register
    always_ff @(posedge CLK50) begin
        if (RST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != S_IDLE);
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = new_write ? S_WR : S_RD;
            S_WR:   if (!pin_ok || 32'(hold_cnt) == HOLD_CYCLES - 1) state_nxt = S_RESP;
            S_RD:   if (!pin_ok || 32'(settle_cnt) == SETTLE_CYCLES) state_nxt = S_RESP;
            S_RESP: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next values for the registered outputs and the shadow
    always_comb begin
        bank_we_nxt   = bank_we;
        rsp_valid_nxt = '0;
        rsp_data_nxt  = rsp_data;
        rsp_err_nxt   = rsp_err;
        shadow_nxt    = shadow;
        hold_nxt      = hold_cnt;
        case (state)
            S_IDLE: begin
                if (accept && new_write && new_pin_ok) begin
                    shadow_nxt[new_pin] = new_data;
                    bank_we_nxt         = 1'b1;
                end
                hold_nxt = '0;
            end
            S_WR: begin
                if (!pin_ok) begin
                    rsp_valid_nxt[owner] = 1'b1;
                    rsp_data_nxt         = cmd_data;
                    rsp_err_nxt          = 1'b1;
                end else if (32'(hold_cnt) == HOLD_CYCLES - 1) begin
                    bank_we_nxt          = 1'b0;
                    rsp_valid_nxt[owner] = 1'b1;
                    rsp_data_nxt         = cmd_data;
                    rsp_err_nxt          = 1'b0;
                end else begin
                    hold_nxt = hold_cnt + HCW'(1);
                end
            end
            S_RD: begin
                if (!pin_ok) begin
                    rsp_valid_nxt[owner] = 1'b1;
                    rsp_data_nxt         = 1'b0;
                    rsp_err_nxt          = 1'b1;
                end else if (32'(settle_cnt) == SETTLE_CYCLES) begin
                    rsp_valid_nxt[owner] = 1'b1;
                    rsp_data_nxt         = bank_in[cmd_pin];
                    rsp_err_nxt          = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; the settle counter tracks how long the bank has been undriven
    always_ff @(posedge CLK50) begin
        if (RST) begin
            ptr        <= '0;
            owner      <= '0;
            cmd_pin    <= '0;
            cmd_data   <= 1'b0;
            hold_cnt   <= '0;
            settle_cnt <= SCW'(SETTLE_CYCLES);
            shadow     <= '0;
            bank_we    <= 1'b0;
            rsp_valid  <= '0;
            rsp_data   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            shadow    <= shadow_nxt;
            bank_we   <= bank_we_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_data  <= rsp_data_nxt;
            rsp_err   <= rsp_err_nxt;
            hold_cnt  <= hold_nxt;
            if (bank_we) settle_cnt <= '0;
            else if (32'(settle_cnt) != SETTLE_CYCLES) settle_cnt <= settle_cnt + SCW'(1);
            if (accept) begin
                owner    <= grant_idx;
                cmd_pin  <= new_pin;
                cmd_data <= new_data;
                ptr      <= (32'(grant_idx) == NREQ - 1) ? '0 : grant_idx + PTRW'(1);
            end
        end
    end

endmodule

// File: tb/tb_io_pins_sequencer.sv
// Bench for io_pins_sequencer: edge-indexed transaction model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with resets.
module tb_io_pins_sequencer;

    localparam int unsigned PINS_COUNT = 17;
    localparam int unsigned NREQ       = 2;
    localparam int unsigned IDXW       = 5;
    localparam int          HOLD       = 4;
    localparam int          SETTLE     = 3;
    localparam int          NR         = 2;

    logic                  CLK50 = 1'b0;
    logic                  RST;
    logic [NREQ-1:0]       req_valid, req_write, req_data, req_ready, rsp_valid;
    logic [NREQ*IDXW-1:0]  req_pin;
    logic                  rsp_data, rsp_err, bank_we, busy;
    logic [PINS_COUNT-1:0] bank_out, bank_in;

    io_pins_sequencer dut (
        .CLK50(CLK50), .RST(RST),
        .req_valid(req_valid), .req_write(req_write), .req_pin(req_pin), .req_data(req_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .bank_we(bank_we), .bank_out(bank_out), .bank_in(bank_in), .busy(busy)
    );

    always #10 CLK50 = ~CLK50;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: every quantity is an absolute rising-edge number.
    // "period n" is the time between edge n and edge n+1.
    int                    cyc = 0;
    bit                    model_on = 0;
    int                    m_ptr, m_free, m_we_from, m_we_to, m_fall, m_rsp_edge, m_owner;
    int                    m_busy_from, m_busy_to, m_samp_edge, m_samp_pin;
    logic                  m_pend_data, m_pend_err, m_data, m_err;
    logic [PINS_COUNT-1:0] m_shadow;
    logic [NREQ-1:0]       m_acc;
    int                    mg;

    function automatic int grant_of(input logic [NREQ-1:0] v, input int p);
        int c;
        grant_of = -1;
        for (int i = NR - 1; i >= 0; i--) begin
            c = (p + i) % NR;
            if (v[c]) grant_of = c;
        end
    endfunction

    task automatic model_reset(input int n);
        m_ptr = 0; m_free = n + 1;
        m_we_from = 1; m_we_to = 0; m_fall = -1000;
        m_rsp_edge = -1000; m_samp_edge = -1000; m_owner = 0;
        m_busy_from = 1; m_busy_to = 0;
        m_data = 1'b0; m_err = 1'b0; m_pend_data = 1'b0; m_pend_err = 1'b0;
        m_shadow = '0;
    endtask

    task automatic model_accept(input int g, input int t);
        int   pin;
        logic wr, d;
        bit   ok;
        pin = int'(req_pin[g*IDXW +: IDXW]);
        wr  = req_write[g];
        d   = req_data[g];
        ok  = pin < int'(PINS_COUNT);
        m_acc[g] = 1'b1;
        m_ptr = (g + 1) % NR;
        m_owner = g;
        m_busy_from = t;
        if (wr && ok) begin
            m_shadow[pin] = d;
            m_we_from = t; m_we_to = t + HOLD; m_fall = t + HOLD;
            m_rsp_edge = t + HOLD;
            m_pend_data = d; m_pend_err = 1'b0;
        end else if (wr) begin
            m_rsp_edge = t + 1;
            m_pend_data = d; m_pend_err = 1'b1;
        end else if (ok) begin
            m_samp_edge = (t + 1 > m_fall + SETTLE + 1) ? t + 1 : m_fall + SETTLE + 1;
            m_samp_pin = pin;
            m_rsp_edge = m_samp_edge;
            m_pend_err = 1'b0;
        end else begin
            m_rsp_edge = t + 1;
            m_pend_data = 1'b0; m_pend_err = 1'b1;
        end
        m_busy_to = m_rsp_edge;
        m_free = m_rsp_edge + 2;
    endtask

    initial forever begin
        @(posedge CLK50);
        cyc++;
        m_acc = '0;
        if (RST) begin
            model_reset(cyc);
            model_on = 1;
        end else if (model_on) begin
            if (cyc == m_samp_edge) m_pend_data = bank_in[m_samp_pin];
            if (cyc == m_rsp_edge) begin
                m_data = m_pend_data;
                m_err  = m_pend_err;
            end
            if (cyc >= m_free) begin
                mg = grant_of(req_valid, m_ptr);
                if (mg >= 0) model_accept(mg, cyc);
            end
        end
    end

    // Per-cycle comparison against the model
    initial forever begin
        logic [NREQ-1:0] exp_rv, exp_rdy;
        int g2;
        @(negedge CLK50);
        if (model_on) begin
            exp_rv = '0;
            if (cyc == m_rsp_edge) exp_rv[m_owner] = 1'b1;
            exp_rdy = '0;
            g2 = (cyc + 1 >= m_free) ? grant_of(req_valid, m_ptr) : -1;
            if (g2 >= 0) exp_rdy[g2] = 1'b1;
            check("bank_we",   32'(bank_we),   32'(cyc >= m_we_from && cyc < m_we_to));
            check("bank_out",  32'(bank_out),  32'(m_shadow));
            check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            check("rsp_data",  32'(rsp_data),  32'(m_data));
            check("rsp_err",   32'(rsp_err),   32'(m_err));
            check("busy",      32'(busy),      32'(cyc >= m_busy_from && cyc <= m_busy_to));
            check("req_ready", 32'(req_ready), 32'(exp_rdy));
        end
    end

    // Issue one command on requester k; lat is the spec-style cycle number of the
    // response relative to the acceptance edge (acceptance edge T -> response at T+lat).
    task automatic do_cmd(input int k, input logic wr, input int pin, input logic d,
                          output int lat, output int we_cnt, output logic rd,
                          output logic re, output logic [NREQ-1:0] who);
        bit acc, got;
        acc = 0; got = 0; lat = 0; we_cnt = 0; rd = 1'b0; re = 1'b0; who = '0;
        @(posedge CLK50); #1;
        req_valid[k] = 1'b1;
        req_write[k] = wr;
        req_pin[k*IDXW +: IDXW] = IDXW'(pin);
        req_data[k] = d;
        for (int i = 0; i < 30 && !acc; i++) begin
            @(posedge CLK50); #1;
            acc = m_acc[k];
        end
        req_valid[k] = 1'b0;
        check("accept_wait", 32'(acc), 32'd1);
        for (int j = 0; j < 40 && acc && !got; j++) begin
            @(negedge CLK50);
            if (bank_we) we_cnt++;
            if (rsp_valid != '0) begin
                got = 1; lat = j + 1; rd = rsp_data; re = rsp_err; who = rsp_valid;
            end
        end
        if (acc) check("rsp_wait", 32'(got), 32'd1);
    endtask

    int              lat, wec, quiet;
    logic            rd, re;
    logic [NREQ-1:0] who;
    logic [NREQ-1:0] owners [4];

    initial begin
        RST = 1'b1; req_valid = '0; req_write = '0; req_pin = '0; req_data = '0; bank_in = '0;
        repeat (3) @(posedge CLK50);
        #1 RST = 1'b0;
        @(negedge CLK50);
        check("rst_bank_we", 32'(bank_we), 32'd0);
        check("rst_bank_out", 32'(bank_out), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Write pin 3 = 1 from requester 0
        do_cmd(0, 1'b1, 3, 1'b1, lat, wec, rd, re, who);
        check("w3_we_cycles", 32'(wec), 32'd4);
        check("w3_latency", 32'(lat), 32'd5);
        check("w3_owner", 32'(who), 32'h1);
        check("w3_data", 32'(rd), 32'd1);
        check("w3_err", 32'(re), 32'd0);
        check("w3_bank_out", 32'(bank_out), 32'h00008);

        // Settled read of pin 16 by requester 1
        bank_in = 17'h10000;
        repeat (3) @(posedge CLK50);
        do_cmd(1, 1'b0, 16, 1'b0, lat, wec, rd, re, who);
        check("r16_latency", 32'(lat), 32'd2);
        check("r16_owner", 32'(who), 32'h2);
        check("r16_data", 32'(rd), 32'd1);

        // Write pin 5 then read it back straight away: turnaround stretches the read
        do_cmd(0, 1'b1, 5, 1'b1, lat, wec, rd, re, who);
        bank_in = 17'h1FFDF;
        do_cmd(0, 1'b0, 5, 1'b0, lat, wec, rd, re, who);
        check("r5_latency", 32'(lat), 32'd3);
        check("r5_data", 32'(rd), 32'd0);
        check("r5_bank_out", 32'(bank_out), 32'h00028);

        // Out-of-range pins
        do_cmd(0, 1'b1, 20, 1'b1, lat, wec, rd, re, who);
        check("w20_we_cycles", 32'(wec), 32'd0);
        check("w20_err", 32'(re), 32'd1);
        check("w20_bank_out", 32'(bank_out), 32'h00028);
        do_cmd(1, 1'b0, 17, 1'b0, lat, wec, rd, re, who);
        check("r17_err", 32'(re), 32'd1);
        check("r17_data", 32'(rd), 32'd0);

        // Reset during the second drive cycle of a write
        @(posedge CLK50); #1;
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_pin[0 +: IDXW] = 5'd7; req_data[0] = 1'b1;
        @(posedge CLK50); #1;
        req_valid[0] = 1'b0;
        check("rw_driving", 32'(bank_we), 32'd1);
        @(posedge CLK50); #1 RST = 1'b1;
        @(posedge CLK50); #1 RST = 1'b0;
        check("rw_bank_we", 32'(bank_we), 32'd0);
        check("rw_bank_out", 32'(bank_out), 32'd0);
        quiet = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK50);
            if (rsp_valid != '0) quiet++;
        end
        check("rw_no_rsp", 32'(quiet), 32'd0);

        // Both requesters hold valid reads: reset pointer gives 0 first, then alternation
        @(posedge CLK50); #1;
        req_write = '0; req_pin = {5'd2, 5'd1}; req_valid = 2'b11;
        for (int r = 0; r < 4; r++) begin
            owners[r] = '0;
            for (int j = 0; j < 20 && owners[r] == '0; j++) begin
                @(negedge CLK50);
                owners[r] = rsp_valid;
            end
        end
        check("rr_0", 32'(owners[0]), 32'h1);
        check("rr_1", 32'(owners[1]), 32'h2);
        check("rr_2", 32'(owners[2]), 32'h1);
        check("rr_3", 32'(owners[3]), 32'h2);
        @(posedge CLK50); #1;
        req_valid = '0;

        // Randomized traffic with occasional resets
        for (int c = 0; c < 4000; c++) begin
            @(posedge CLK50); #1;
            RST = ($urandom_range(0, 299) == 0);
            bank_in = PINS_COUNT'($urandom);
            for (int k = 0; k < NR; k++) begin
                if (m_acc[k]) req_valid[k] = 1'b0;
                if (!req_valid[k] && $urandom_range(0, 3) == 0) begin
                    req_write[k] = 1'($urandom_range(0, 1));
                    req_pin[k*IDXW +: IDXW] = IDXW'($urandom_range(0, 22));
                    req_data[k] = 1'($urandom_range(0, 1));
                    req_valid[k] = 1'b1;
                end
            end
        end
        @(posedge CLK50); #1;
        RST = 1'b0; req_valid = '0;
        repeat (12) @(posedge CLK50);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_pins_sequencer.md
Name: io_pins_sequencer

Overview:
Sequences and shares the bidirectional FPGA pin bank between NREQ requesters, one single-pin read or write at a time. The bank has one global direction, so the block owns it: it drives the bank's write_enable and its output-value vector from a shadow register, and samples the bank's input vector. It sits between the test/host command logic and the io-pin driver. It guarantees drive-hold and turnaround timing, and arbitrates round-robin.

Parameters:
PINS_COUNT, 17, number of pins in the bank
NREQ, 2, number of requesters
IDXW, 5, pin-index width (>= $clog2(PINS_COUNT))
HOLD_CYCLES, 4, cycles bank_we stays high per write (>=1)
SETTLE_CYCLES, 3, cycles bank_we must be low before a read sample (>=1)

Ports:
CLK50  in  1  clock, all logic on rising edge
RST  in  1  reset, synchronous, active-high
req_valid  in  NREQ  per-requester command valid; held until accepted
req_write  in  NREQ  1 = write, 0 = read
req_pin  in  NREQ*IDXW  pin index, requester k at bits [k*IDXW +: IDXW]
req_data  in  NREQ  write value, one bit per requester
req_ready  out  NREQ  accept strobe; one-hot, combinational, only in IDLE
rsp_valid  out  NREQ  one-cycle response pulse to the owning requester
rsp_data  out  1  read value, or the echoed write value
rsp_err  out  1  pin index >= PINS_COUNT; valid with rsp_valid
bank_we  out  1  bank direction: 1 = drive bank_out
bank_out  out  PINS_COUNT  shadow drive values
bank_in  in  PINS_COUNT  sampled pin levels
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: bank_we=0; bank_out=all 0; rsp_valid=0; rsp_data=0; rsp_err=0; busy=0; state IDLE; round-robin pointer=0 (requester 0 has first priority); settle counter saturated at SETTLE_CYCLES.
- Handshake: a command transfers on a cycle with req_valid[k] & req_ready[k]. Command fields are latched on that edge.
- Arbitration in IDLE:
  - Search starts at the pointer and wraps modulo NREQ; the first valid requester is granted.
  - The pointer moves to grant+1 (wrapping) on acceptance.
  - req_ready is 0 outside IDLE.
- Settle counter: cleared to 0 on any cycle bank_we=1; otherwise increments, saturating at SETTLE_CYCLES.
- States:
  - IDLE: accept a command, then go to WR or RD.
  - WR:
    - Valid pin: shadow[pin] <= data on entry; bank_we=1 for exactly HOLD_CYCLES cycles, then go to RESP.
    - Invalid pin: no shadow update, no drive, go directly to RESP with rsp_err=1.
  - RD:
    - Wait while the settle counter < SETTLE_CYCLES.
    - On the first cycle it equals SETTLE_CYCLES, register bank_in[pin] into rsp_data and go to RESP.
    - Invalid pin: rsp_data=0, rsp_err=1, no wait.
  - RESP: rsp_valid[owner]=1 for one cycle; rsp_data/rsp_err held until the next response. Then go to IDLE.
- Latency, with acceptance at edge T:
  - Valid write: bank_we high for cycles T+1..T+HOLD_CYCLES; rsp_valid at cycle T+HOLD_CYCLES+1 (T+5 with defaults).
  - Read with the bank already settled: sample at T+1, rsp_valid at T+2.
  - Read directly after a write: the sample waits until bank_we has been low for SETTLE_CYCLES cycles.
- bank_out reflects the shadow at all times, including while bank_we=0. Values persist across commands.
- A new request arriving during RESP is not accepted until the following IDLE cycle, so the minimum spacing between acceptances is 3 cycles.
- Reset mid-operation: at the reset edge bank_we drops to 0, the in-flight command is discarded with no response, and the shadow clears to 0.
- At most one command is in flight. Requesters must not change their command fields while valid and not accepted.

Test Plan:
- Reset, then requester 0 writes pin 3 = 1 -> bank_we high for exactly 4 cycles; bank_out = 0x00008; rsp_valid[0] pulses at T+5 with rsp_data=1, rsp_err=0.
- Idle ≥3 cycles, bank_in = 0x10000, requester 1 reads pin 16 -> rsp_valid[1] at T+2, rsp_data=1.
- Write pin 5 = 1, then immediately read pin 5 with bank_in bit5=0 -> sample taken only after 3 cycles of bank_we=0; rsp_data=0; bank_out bit5 still 1.
- Both requesters hold valid reads continuously after reset -> grants alternate 0,1,0,1; each response goes only to its owner.
- Requester 0 writes pin 20 -> no bank_we pulse; bank_out unchanged; rsp_valid[0] with rsp_err=1. A read of pin 17 -> rsp_err=1, rsp_data=0.
- Assert RST during the 2nd cycle of a write's drive -> bank_we=0 and bank_out=0 after that edge; no rsp_valid; pointer reset so requester 0 wins the next simultaneous request.
